rx_package: RTL
===============

Name: rx_package

Overview:
RS-232 receive stage that sits directly downstream of the serial transmitter on the same line. It deserialises a package of BYTES frames into one word. Each frame is 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1); byte 0 carries word bits [7:0]. The assembled 32-bit word is handed to the AES datapath with a one-cycle valid pulse.

Parameters:
BIT_CYCLES, 48, clock cycles per serial bit; must match the transmitter bit period.
BYTES, 4, frames per package; BYTES*8 = 32.
TIMEOUT_CYCLES, 480, maximum idle cycles allowed between the stop bit of one frame and the start bit of the next within a package.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
data_in  input  1  serial line, idle high, asynchronous to clk
data_out  output  32  last completely received word; holds until the next good package
data_valid  output  1  one-cycle pulse; data_out is new on this cycle
frame_err  output  1  one-cycle pulse; stop bit sampled as 0, partial package discarded
timeout_err  output  1  one-cycle pulse; next start bit not seen in time, partial package discarded
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Input path: data_in passes through a 2-flop synchroniser, then a registered copy used for edge detection. A start edge is a sampled 1 followed by a sampled 0.
- Reset (any state, any cycle):
  - State = IDLE; all counters and the shift register = 0.
  - data_out = 0; data_valid, frame_err, timeout_err, busy = 0.
  - Synchroniser flops = 1.
- Bit counter: 0..BIT_CYCLES-1, with width sized by $clog2.
- Data bit counter: 0..8.
- Byte counter: 0..BYTES.
- IDLE:
  - Start edge -> START; bit counter cleared; byte counter cleared.
- START:
  - Waits until bit counter = BIT_CYCLES/2-1 (mid start bit), then samples the line.
  - Sample 0 -> DATA; bit counter cleared.
  - Sample 1 (glitch) -> IDLE if byte counter = 0, else GAP. No error pulse in either case.
- DATA:
  - Each time bit counter = BIT_CYCLES-1: sample; shift register <= {sample, shift[31:1]}; data bit counter increments; bit counter clears.
  - After the 8th sample -> STOP.
- STOP:
  - Samples at bit counter = BIT_CYCLES-1.
  - Sample 1: byte counter increments. If the new count = BYTES -> DONE; otherwise -> GAP with the timeout counter cleared.
  - Sample 0: frame_err pulses the next cycle -> IDLE. Shift register and byte counter are discarded; data_out is unchanged.
- GAP:
  - Start edge -> START.
  - Timeout counter reaching TIMEOUT_CYCLES-1 -> timeout_err pulses the next cycle -> IDLE.
  - Start edge and timeout on the same cycle: the start edge wins.
- DONE (one cycle):
  - data_out <= shift register; data_valid = 1 -> IDLE.
  - Latency: data_valid is high exactly 1 cycle after the last stop-bit sample.
- The line must return high before a new start is recognised after a frame error, because the edge detector requires a 1 before the 0.
- A start edge on the cycle data_valid is high is accepted, so back-to-back packages are not lost.
- data_valid, frame_err and timeout_err are mutually exclusive and never high for two consecutive cycles.
- Word order is the exact inverse of the transmitter: the first serial data bit becomes data_out[0], and the last becomes data_out[31].

Test Plan:
1. Send 32'hA5C3_0F81 as frames 81, 0F, C3, A5 at 48 cycles/bit with a 96-cycle inter-frame gap -> data_out = 32'hA5C3_0F81; data_valid high for 1 cycle; no error pulses.
2. Drive data_in low for 10 cycles while idle, then high -> state returns to IDLE; busy drops; no data_valid or error pulses.
3. Normal frames 0 and 1, then frame 2 with stop bit = 0 -> frame_err pulses once; data_out keeps its previous value; the next complete package 32'h1234_5678 is received correctly.
4. Send 2 frames, then hold the line high for 600 cycles -> timeout_err pulses 480 cycles after the second stop sample; busy = 0; no data_valid.
5. Assert rst for 1 cycle in the middle of frame 1's data bits -> all outputs reset the next cycle; the following full package 32'hDEAD_BEEF is received with data_valid.
6. Two packages back-to-back with the minimum 1-bit gap (32'h0000_0001, then 32'hFFFF_FFFF) -> two data_valid pulses with the correct words in order.

Source files
------------

// File: rtl/rx_package.sv
// rx_package: RS-232 receiver that assembles BYTES 8N1 frames (LSB first) into one word.
// A good package, a bad stop bit or an over-long inter-frame gap each produce a one-cycle pulse.
module rx_package #(
   parameter int BIT_CYCLES     = 48,
   parameter int BYTES          = 4,
   parameter int TIMEOUT_CYCLES = 480
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 data_in,
   output logic [BYTES*8-1:0]   data_out,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 timeout_err,
   output logic                 busy
);
   localparam int W   = BYTES * 8;
   localparam int BCW = $clog2(BIT_CYCLES);
   localparam int YCW = $clog2(BYTES + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES);
   localparam logic [BCW-1:0] BIT_MID   = BCW'(BIT_CYCLES / 2 - 1);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(BIT_CYCLES - 1);
   localparam logic [YCW-1:0] BYTE_LAST = YCW'(BYTES - 1);
   localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP, S_DONE} state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync2_q, prev_q;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [3:0]       dbit_cnt_q, dbit_cnt_d;
   logic [YCW-1:0]   byte_cnt_q, byte_cnt_d;
   logic [TCW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic [W-1:0]     shift_q, shift_d;
   logic [W-1:0]     data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             terr_q, terr_d;
   logic             line;
   logic             start_edge;

   assign line       = sync2_q;
   assign start_edge = prev_q & ~sync2_q;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      dbit_cnt_d = dbit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      shift_d    = shift_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;
      terr_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_edge) begin
               state_d    = S_START;
               bit_cnt_d  = '0;
               byte_cnt_d = '0;
            end
         end
         S_START: begin
            if (bit_cnt_q == BIT_MID) begin
               bit_cnt_d = '0;
               if (!line) begin
                  state_d    = S_DATA;
                  dbit_cnt_d = '0;
               end else begin
                  // Glitch: resume waiting without reporting anything
                  state_d = (byte_cnt_q == '0) ? S_IDLE : S_GAP;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d  = '0;
               shift_d    = {line, shift_q[W-1:1]};
               dbit_cnt_d = dbit_cnt_q + 1'b1;
               if (dbit_cnt_q == 4'd7) state_d = S_STOP;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = '0;
               if (line) begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  if (byte_cnt_q == BYTE_LAST) begin
                     // Word and valid are loaded together so they appear in DONE
                     state_d = S_DONE;
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     state_d   = S_GAP;
                     tmo_cnt_d = '0;
                  end
               end else begin
                  state_d    = S_IDLE;
                  ferr_d     = 1'b1;
                  shift_d    = '0;
                  byte_cnt_d = '0;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (start_edge) begin
               state_d   = S_START;
               bit_cnt_d = '0;
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d    = S_IDLE;
               terr_d     = 1'b1;
               shift_d    = '0;
               byte_cnt_d = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (start_edge) begin
               state_d    = S_START;
               bit_cnt_d  = '0;
               byte_cnt_d = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         prev_q     <= 1'b1;
         bit_cnt_q  <= '0;
         dbit_cnt_q <= '0;
         byte_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         terr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync1_q    <= data_in;
         sync2_q    <= sync1_q;
         prev_q     <= sync2_q;
         bit_cnt_q  <= bit_cnt_d;
         dbit_cnt_q <= dbit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
         terr_q     <= terr_d;
      end
   end

   assign data_out    = data_q;
   assign data_valid  = valid_q;
   assign frame_err   = ferr_q;
   assign timeout_err = terr_q;
   assign busy        = (state_q != S_IDLE);
endmodule
